irq_priority_ctrl: RTL and testbench
====================================

Name: irq_priority_ctrl

Overview:
- Interrupt controller for the risc32i core.
- Latches rising edges from N interrupt sources and masks them with an enable vector.
- Picks the highest-index enabled pending source (highest index = highest priority) and presents it to the CPU through a request/acknowledge/end-of-interrupt handshake.
- Non-nesting: only one interrupt is in service at a time.

Parameters:
N, 8, number of interrupt sources; legal range 2..32
ID_W, 3, width of the source index; must equal clog2(N)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
irq_src  input  N  raw level interrupt lines, rising edge detected
irq_en  input  N  per-source enable mask, 1 = enabled
irq_ack  input  1  CPU accepts the presented interrupt; single-cycle pulse
irq_eoi  input  1  CPU finished servicing; single-cycle pulse
irq_req  output  1  interrupt request to CPU
irq_id  output  ID_W  index of the requested or in-service source
in_service  output  1  an interrupt is being serviced
pending  output  N  latched pending bits, readable by software

Behaviour:
- Reset:
  - rst_n=0 at a clk edge clears src_prev, pending, irq_req, irq_id, in_service and the FSM (state = IDLE).
  - This applies in every state, including mid-service.
  - src_prev resets to 0, so a source already high at reset release is latched on the first sampled cycle.
- Edge detect:
  - edge[i] = irq_src[i] & ~src_prev[i].
  - src_prev <= irq_src every cycle.
- Pending update:
  - pending[i] sets on edge[i] whether or not irq_en[i] is set; masked edges are held, not lost.
  - pending[i] clears only on an accepted ack for id i.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Selection (combinational):
  - cand = pending & irq_en.
  - win = index of the highest set bit of cand; win = 0 when cand = 0.
- FSM states IDLE, REQ, SERVICE; all outputs registered.
- IDLE:
  - irq_req=0, in_service=0.
  - cand!=0 -> REQ, with irq_id <= win.
- REQ:
  - irq_req=1.
  - Each cycle irq_id <= win, so a higher-priority arrival replaces the candidate before ack.
  - cand==0 (masked or cleared) -> IDLE, irq_req drops.
  - irq_ack=1 -> SERVICE: pending[irq_id] clears and irq_id is frozen.
  - The id accepted is the irq_id value visible in the ack cycle.
- SERVICE:
  - in_service=1, irq_req=0, irq_id holds the accepted id.
  - irq_eoi=1 -> IDLE.
  - New pending interrupts wait; no preemption.
- Ignored inputs:
  - irq_ack is ignored outside REQ.
  - irq_eoi is ignored outside SERVICE.
  - ack and eoi together in REQ act as ack only.
- Latency:
  - src rise sampled at edge k -> pending bit visible after edge k.
  - irq_req=1 and irq_id valid after edge k+1.
  - irq_ack at edge m -> in_service=1, irq_req=0 after edge m.
  - irq_eoi at edge m -> IDLE after edge m; a remaining cand re-raises irq_req after edge m+1.
- irq_id outside REQ/SERVICE holds its last value; software must not rely on it.

Test Plan:
1. Single source: reset, then irq_src=0x04, irq_en=0xFF -> pending=0x04 after 1 cycle; irq_req=1, irq_id=2 after 2 cycles; ack -> pending=0x00, in_service=1; eoi -> in_service=0, irq_req stays 0.
2. Priority: irq_src rises 0x12 in one cycle, all enabled -> irq_id=4.
   - Ack, then eoi -> irq_id=1 re-requested one cycle after eoi.
   - Ack, then eoi -> all clear.
3. Late higher priority: in REQ with irq_id=1, source 6 rises before ack -> irq_id=6 the cycle after pending[6] sets; ack clears pending[6] only, pending=0x02.
4. Masking: irq_en=0x00, source 3 rises -> pending=0x08, irq_req stays 0; set irq_en=0x08 -> irq_req=1, irq_id=3 next cycle; clear irq_en while in REQ -> back to IDLE, irq_req=0, pending still 0x08.
5. Ignored handshakes and same-bit re-edge:
   - Stray irq_ack in IDLE and irq_eoi in REQ -> no state change.
   - Source 5 re-rises (after a low cycle) during its own ack cycle -> pending[5] remains 1 after ack.
6. Reset mid-service: in SERVICE with pending=0x21, assert rst_n=0 for one cycle -> all outputs 0, state IDLE; sources held high at release are re-latched, giving pending=0x21 one cycle later.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl
//   Interrupt controller for the risc32i core. Rising edges on irq_src are
//   latched into pending, masked by irq_en, and the highest-index enabled
//   pending source is presented to the CPU through a req/ack/eoi handshake.
//   Only one interrupt is in service at a time (no nesting, no preemption).
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   irq_src     raw level interrupt lines (rising edge detected)
//   irq_en      per-source enable mask, 1 = enabled
//   irq_ack     CPU accepts the presented interrupt (1-cycle pulse)
//   irq_eoi     CPU finished servicing (1-cycle pulse)
//   irq_req     interrupt request to CPU
//   irq_id      index of requested / in-service source
//   in_service  an interrupt is being serviced
//   pending     latched pending bits, readable by software
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing requested or in service; waits for an enabled pending
// REQ     | irq_req high, irq_id tracks the current winner until ack
// SERVICE | accepted id frozen, in_service high, waits for eoi

module irq_priority_ctrl #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    irq_src,
   input  logic [N-1:0]    irq_en,
   input  logic            irq_ack,
   input  logic            irq_eoi,
   output logic            irq_req,
   output logic [ID_W-1:0] irq_id,
   output logic            in_service,
   output logic [N-1:0]    pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t          state;
   logic [N-1:0]    src_prev;
   logic [N-1:0]    src_edge;
   logic [N-1:0]    cand;
   logic [N-1:0]    clr;
   logic [ID_W-1:0] win;
   logic            ack_fire;

   assign src_edge = irq_src & ~src_prev;
   assign cand     = pending & irq_en;

   // Ack only counts while requesting something that is still a candidate;
   // if the candidate vanished this cycle the FSM falls back to IDLE instead.
   assign ack_fire = (state == REQ) && (cand != '0) && irq_ack;

   // Ascending scan: the last hit is the highest index, i.e. highest priority.
   always_comb begin
      win = '0;
      for (int i = 0; i < N; i++) begin
         if (cand[i]) win = ID_W'(i);
      end
   end

   always_comb begin
      clr = '0;
      if (ack_fire) clr[irq_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_prev   <= '0;
         pending    <= '0;
         state      <= IDLE;
         irq_req    <= 1'b0;
         irq_id     <= '0;
         in_service <= 1'b0;
      end else begin
         src_prev <= irq_src;
         // A new edge on the bit being acked in the same cycle survives.
         pending  <= (pending & ~clr) | src_edge;

         case (state)
            IDLE: begin
               if (cand != '0) begin
                  state   <= REQ;
                  irq_req <= 1'b1;
                  irq_id  <= win;
               end
            end
            REQ: begin
               if (cand == '0) begin
                  state   <= IDLE;
                  irq_req <= 1'b0;
               end else if (irq_ack) begin
                  state      <= SERVICE;
                  irq_req    <= 1'b0;
                  in_service <= 1'b1;
               end else begin
                  irq_id <= win;
               end
            end
            SERVICE: begin
               if (irq_eoi) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               irq_req    <= 1'b0;
               in_service <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;

   localparam int N    = 8;
   localparam int ID_W = 3;

   logic            clk_sys = 1'b0;
   logic            rst_n;
   logic [N-1:0]    irq_src;
   logic [N-1:0]    irq_en;
   logic            irq_ack;
   logic            irq_eoi;
   logic            irq_req;
   logic [ID_W-1:0] irq_id;
   logic            in_service;
   logic [N-1:0]    pending;

   int checks   = 0;
   int failures = 0;

   irq_priority_ctrl #(.N(N), .ID_W(ID_W)) dut (
      .clk        (clk_sys),
      .rst_n      (rst_n),
      .irq_src    (irq_src),
      .irq_en     (irq_en),
      .irq_ack    (irq_ack),
      .irq_eoi    (irq_eoi),
      .irq_req    (irq_req),
      .irq_id     (irq_id),
      .in_service (in_service),
      .pending    (pending)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk_sys);
   endtask

   task automatic chk_out(input string tag, input logic req, input logic [ID_W-1:0] id,
                          input logic svc, input logic [N-1:0] pend);
      chk({tag, ".req"}, 32'(irq_req), 32'(req));
      chk({tag, ".id"},  32'(irq_id),  32'(id));
      chk({tag, ".svc"}, 32'(in_service), 32'(svc));
      chk({tag, ".pend"}, 32'(pending), 32'(pend));
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; irq_src = '0; irq_en = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
      step(); step();
      chk_out("rst", 1'b0, 3'd0, 1'b0, 8'h00);
      rst_n = 1'b1;

      // 1: single source
      irq_en = 8'hFF; irq_src = 8'h04;
      step(); chk_out("t1.pend", 1'b0, 3'd0, 1'b0, 8'h04);
      step(); chk_out("t1.req",  1'b1, 3'd2, 1'b0, 8'h04);
      pulse_ack(); chk_out("t1.ack", 1'b0, 3'd2, 1'b1, 8'h00);
      pulse_eoi(); chk_out("t1.eoi", 1'b0, 3'd2, 1'b0, 8'h00);
      step(); chk("t1.idle_req", 32'(irq_req), 32'd0);
      irq_src = '0; step();

      // 2: priority between two simultaneous edges
      irq_src = 8'h12;
      step(); chk_out("t2.pend", 1'b0, 3'd2, 1'b0, 8'h12);
      step(); chk_out("t2.req4", 1'b1, 3'd4, 1'b0, 8'h12);
      pulse_ack(); chk_out("t2.ack4", 1'b0, 3'd4, 1'b1, 8'h02);
      pulse_eoi(); chk_out("t2.eoi4", 1'b0, 3'd4, 1'b0, 8'h02);
      step(); chk_out("t2.req1", 1'b1, 3'd1, 1'b0, 8'h02);
      pulse_ack(); chk_out("t2.ack1", 1'b0, 3'd1, 1'b1, 8'h00);
      pulse_eoi(); chk_out("t2.clear", 1'b0, 3'd1, 1'b0, 8'h00);
      irq_src = '0; step();

      // 3: higher priority arrives while requesting
      irq_src = 8'h02; step(); step();
      chk_out("t3.req1", 1'b1, 3'd1, 1'b0, 8'h02);
      irq_src = 8'h42;
      step(); chk_out("t3.pend6", 1'b1, 3'd1, 1'b0, 8'h42);
      step(); chk_out("t3.req6", 1'b1, 3'd6, 1'b0, 8'h42);
      pulse_ack(); chk_out("t3.ack6", 1'b0, 3'd6, 1'b1, 8'h02);
      pulse_eoi(); step();
      chk_out("t3.req1b", 1'b1, 3'd1, 1'b0, 8'h02);
      pulse_ack(); pulse_eoi();
      chk_out("t3.clear", 1'b0, 3'd1, 1'b0, 8'h00);
      irq_src = '0; step();

      // 4: masking holds the edge without requesting
      irq_en = 8'h00; irq_src = 8'h08;
      step(); step(); chk_out("t4.masked", 1'b0, 3'd1, 1'b0, 8'h08);
      irq_en = 8'h08;
      step(); chk_out("t4.unmask", 1'b1, 3'd3, 1'b0, 8'h08);
      irq_en = 8'h00;
      step(); chk_out("t4.remask", 1'b0, 3'd3, 1'b0, 8'h08);
      step(); chk("t4.still_idle", 32'(irq_req), 32'd0);
      irq_en = 8'hFF; step(); pulse_ack(); pulse_eoi();
      chk_out("t4.clear", 1'b0, 3'd3, 1'b0, 8'h00);
      irq_src = '0; step();

      // 5: stray handshakes, re-edge during own ack
      pulse_ack(); chk_out("t5.stray_ack", 1'b0, 3'd3, 1'b0, 8'h00);
      irq_src = 8'h20; step(); step();
      chk_out("t5.req5", 1'b1, 3'd5, 1'b0, 8'h20);
      pulse_eoi(); chk_out("t5.stray_eoi", 1'b1, 3'd5, 1'b0, 8'h20);
      irq_src = 8'h00; step();
      irq_src = 8'h20; pulse_ack();
      chk_out("t5.reedge", 1'b0, 3'd5, 1'b1, 8'h20);
      pulse_eoi(); step();
      chk_out("t5.rereq", 1'b1, 3'd5, 1'b0, 8'h20);
      irq_ack = 1'b1; irq_eoi = 1'b1; step(); irq_ack = 1'b0; irq_eoi = 1'b0;
      chk_out("t5.ack_eoi", 1'b0, 3'd5, 1'b1, 8'h00);
      pulse_eoi();
      irq_src = '0; step();

      // 6: reset in the middle of service
      irq_src = 8'h21; step(); step();
      chk_out("t6.req5", 1'b1, 3'd5, 1'b0, 8'h21);
      pulse_ack(); chk_out("t6.ack5", 1'b0, 3'd5, 1'b1, 8'h01);
      irq_src = 8'h01; step();
      irq_src = 8'h21; step();
      chk_out("t6.svc", 1'b0, 3'd5, 1'b1, 8'h21);
      rst_n = 1'b0; step();
      chk_out("t6.rst", 1'b0, 3'd0, 1'b0, 8'h00);
      rst_n = 1'b1; step();
      chk_out("t6.relatch", 1'b0, 3'd0, 1'b0, 8'h21);
      step(); chk_out("t6.rereq", 1'b1, 3'd5, 1'b0, 8'h21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
